addsub_issue: RTL and testbench

Operand issue stage directly upstream of the team's 4-bit add/subtract unit. It accepts operand sets over a valid/ready handshake and queues them in a small FIFO. It presents one set at a time on registered outputs to the combinational adder, samples the 5-bit result one cycle later, and offers it downstream over a second valid/ready handshake with backpressure.

---
 rtl/addsub_issue.sv | 127 ++++++++++++
 tb/tb_addsub_issue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_issue.sv
// Operand issue stage for the 4-bit add/subtract unit: queues operand sets,
// drives them to the combinational adder one at a time, and holds each result for downstream.
module addsub_issue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_a,
    input  logic [3:0]             in_b,
    input  logic                   in_cin,
    input  logic                   in_mode,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    output logic                   add_z,
    input  logic [4:0]             add_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_x,
    output logic                   out_mode,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             done_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       mode;
    } op_t;

    typedef enum logic {IDLE, EVAL} state_t;

    op_t             mem [DEPTH];
    op_t             head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    state_t          state_q, state_d;
    logic            push, pop, capture, slot_free, handshake;

    assign in_ready  = (fifo_level != FULL);
    assign push      = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign handshake = out_valid && out_ready;
    assign head      = mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{a: in_a, b: in_b, cin: in_cin, mode: in_mode};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_level != '0) state_d = EVAL;
            EVAL:    if (slot_free)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE:    pop     = (fifo_level != '0);
            EVAL:    capture = slot_free;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
            add_z   <= 1'b0;
        end else if (pop) begin
            add_a   <= head.a;
            add_b   <= head.b;
            add_cin <= head.cin;
            add_z   <= head.mode;
        end
    end

    // A capture in the same cycle as a handshake keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_mode   <= 1'b0;
            done_count <= '0;
        end else begin
            if (capture) begin
                out_x     <= add_sum;
                out_mode  <= add_z;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
            if (handshake) done_count <= done_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_addsub_issue.sv
// Directed bench for addsub_issue with a combinational adder model on the add_* port.
module tb_addsub_issue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0, in_ready;
    logic [3:0] in_a = '0, in_b = '0;
    logic       in_cin = 1'b0, in_mode = 1'b0;
    logic [3:0] add_a, add_b;
    logic       add_cin, add_z;
    logic [4:0] add_sum;
    logic       out_valid, out_ready = 1'b0;
    logic [4:0] out_x;
    logic       out_mode;
    logic [2:0] fifo_level;
    logic [7:0] done_count;

    int n_vec = 0;
    int n_err = 0;

    addsub_issue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_z(add_z),
        .add_sum(add_sum), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_mode(out_mode), .fifo_level(fifo_level),
        .done_count(done_count)
    );

    // Adder: 5-bit modulo result {c_out,d}
    assign add_sum = add_z ? ({1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin})
                           : ({1'b0, add_a} - {1'b0, add_b} + {4'b0, add_cin});

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic c, input logic m);
        bit ok = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = c; in_mode = m;
        for (int i = 0; i < 40; i++) begin
            ok = in_ready;
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) chk("issue_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic get_result(input string tag, input logic [4:0] ex, input logic em);
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                chk({tag, "_x"}, 32'(out_x), 32'(ex));
                chk({tag, "_mode"}, 32'(out_mode), 32'(em));
                got = 1;
                tick();
                break;
            end
            tick();
        end
        if (!got) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic c, input logic m);
        logic [4:0] r;
        if (m) r = 5'(a) + 5'(b) + 5'(c);
        else   r = 5'(a) - 5'(b) + 5'(c);
        return r;
    endfunction

    logic [3:0] bp_a   [8] = '{4'd3, 4'd9, 4'd5, 4'd12, 4'd15, 4'd0, 4'd8, 4'd1};
    logic [3:0] bp_b   [8] = '{4'd4, 4'd9, 4'd7, 4'd2,  4'd15, 4'd1, 4'd8, 4'd0};
    logic       bp_c   [8] = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b1,  1'b1, 1'b0, 1'b0};
    logic       bp_m   [8] = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1,  1'b0, 1'b1, 1'b0};
    logic [4:0] bp_exp [8] = '{5'd7, 5'd19, 5'd30, 5'd10, 5'd31, 5'd0, 5'd16, 5'd1};

    initial begin
        int acc;
        bit was;
        logic [3:0] ra, rb;
        logic rc, rm;

        // Mid-cycle reset takes effect without a clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_done", 32'(done_count), 32'd0);
        chk("rst_add", 32'({add_a, add_b, add_cin, add_z}), 32'd0);
        chk("rst_out_x", 32'({out_x, out_mode}), 32'd0);
        #3 rst_n = 1'b1;
        tick();

        // Subtract with exact latency
        out_ready = 1'b1;
        issue(4'b1011, 4'b0110, 1'b1, 1'b0);
        chk("sub_level_t", 32'(fifo_level), 32'd1);
        chk("sub_valid_t", 32'(out_valid), 32'd0);
        tick();
        chk("sub_add_a", 32'(add_a), 32'b1011);
        chk("sub_add_b", 32'(add_b), 32'b0110);
        chk("sub_add_z", 32'(add_z), 32'd0);
        chk("sub_valid_t1", 32'(out_valid), 32'd0);
        tick();
        chk("sub_valid_t2", 32'(out_valid), 32'd1);
        chk("sub_x", 32'(out_x), 32'b00110);
        chk("sub_mode", 32'(out_mode), 32'd0);
        tick();
        chk("sub_done", 32'(done_count), 32'd1);
        chk("sub_valid_drop", 32'(out_valid), 32'd0);

        // Add and subtract with wrap, back to back, in order
        issue(4'b1111, 4'b0001, 1'b1, 1'b1);
        issue(4'b0010, 4'b0101, 1'b0, 1'b0);
        get_result("wrap_add", 5'b10001, 1'b1);
        get_result("wrap_sub", 5'b11101, 1'b0);
        chk("wrap_done", 32'(done_count), 32'd3);

        // Backpressure: DEPTH + 2 absorbed
        apply_reset();
        tick();
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            in_a = bp_a[acc]; in_b = bp_b[acc]; in_cin = bp_c[acc]; in_mode = bp_m[acc];
            was = in_ready;
            tick();
            if (was) acc++;
            if (acc == 8) break;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd6);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_level", 32'(fifo_level), 32'd4);
        chk("bp_stall_valid", 32'(out_valid), 32'd1);
        chk("bp_stall_x", 32'(out_x), 32'(bp_exp[0]));
        chk("bp_done_stall", 32'(done_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) get_result($sformatf("bp_%0d", i), bp_exp[i], bp_m[i]);
        chk("bp_done", 32'(done_count), 32'd6);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);

        // Reset in the middle of a stalled workload
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) issue(bp_a[i], bp_b[i], bp_c[i], bp_m[i]);
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        chk("mid_pre_level", 32'(fifo_level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_level", 32'(fifo_level), 32'd0);
        chk("mid_done", 32'(done_count), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        issue(4'b1011, 4'b0110, 1'b1, 1'b0);
        chk("mid_lat0", 32'(out_valid), 32'd0);
        tick();
        chk("mid_lat1", 32'(out_valid), 32'd0);
        tick();
        chk("mid_lat2", 32'(out_valid), 32'd1);
        chk("mid_lat2_x", 32'(out_x), 32'b00110);
        tick();
        chk("mid_after_done", 32'(done_count), 32'd1);
        chk("mid_no_stale", 32'(out_valid), 32'd0);

        // done_count wrap
        apply_reset();
        tick();
        for (int i = 0; i < 256; i++) begin
            ra = 4'($urandom_range(15)); rb = 4'($urandom_range(15));
            rc = 1'($urandom_range(1));  rm = 1'($urandom_range(1));
            issue(ra, rb, rc, rm);
            get_result("cnt", model(ra, rb, rc, rm), rm);
            if (i == 254) chk("cnt_255", 32'(done_count), 32'd255);
        end
        chk("cnt_wrap0", 32'(done_count), 32'd0);
        issue(4'd7, 4'd8, 1'b0, 1'b1);
        get_result("cnt_257", 5'd15, 1'b1);
        chk("cnt_wrap1", 32'(done_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
